// File: rtl/async_fifo.sv
// Gray-pointer FIFO (16x32 default), 2-flop pointer synchronisers, CDC-ready though single-clocked.
// Read data 1 cycle after an accepted read; writes dropped while o_wfull, reads dropped while o_rempty.
module async_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_wr,
  input  logic                  i_rd,
  output logic                  o_wfull,
  output logic                  o_rempty,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0] wbin, wgray, next_wbin, next_wgray;
  logic [ADDR_WIDTH:0] rbin, rgray, next_rbin, next_rgray;
  logic [ADDR_WIDTH:0] wq1_rgray, wq2_rgray, rq1_wgray, rq2_wgray;
  logic [ADDR_WIDTH:0] wfull_cmp;
  logic                w_acc, r_acc;

  assign w_acc      = i_wr & ~o_wfull;
  assign r_acc      = i_rd & ~o_rempty;
  assign next_wbin  = wbin + {{ADDR_WIDTH{1'b0}}, w_acc};
  assign next_rbin  = rbin + {{ADDR_WIDTH{1'b0}}, r_acc};
  assign next_wgray = next_wbin ^ (next_wbin >> 1);
  assign next_rgray = next_rbin ^ (next_rbin >> 1);

  // Full when the write pointer is exactly one lap ahead: top two Gray bits differ, rest equal.
  assign wfull_cmp  = {~wq2_rgray[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rgray[ADDR_WIDTH-2:0]};

  always_ff @(posedge i_clk) begin
    if (w_acc) mem[wbin[ADDR_WIDTH-1:0]] <= i_wdata;
  end

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      wbin    <= '0;
      wgray   <= '0;
      o_wfull <= 1'b0;
    end else begin
      wbin    <= next_wbin;
      wgray   <= next_wgray;
      o_wfull <= (next_wgray == wfull_cmp);
    end
  end

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      rbin     <= '0;
      rgray    <= '0;
      o_rempty <= 1'b1;
      o_rdata  <= '0;
    end else begin
      rbin     <= next_rbin;
      rgray    <= next_rgray;
      o_rempty <= (next_rgray == rq2_wgray);
      if (r_acc) o_rdata <= mem[rbin[ADDR_WIDTH-1:0]];
    end
  end

  // Each pointer reaches the opposite side two edges later, so flags release conservatively.
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      wq1_rgray <= '0;
      wq2_rgray <= '0;
      rq1_wgray <= '0;
      rq2_wgray <= '0;
    end else begin
      wq1_rgray <= rgray;
      wq2_rgray <= wq1_rgray;
      rq1_wgray <= wgray;
      rq2_wgray <= rq1_wgray;
    end
  end

endmodule

// File: tb/tb_async_fifo.sv
// Directed bench for async_fifo: fill/overflow, drain/underflow, flag lag at full and empty, mid-run reset.
module tb_async_fifo;

  logic        i_clk = 1'b0;
  logic        rst;
  logic [31:0] i_wdata;
  logic        i_wr;
  logic        i_rd;
  logic        o_wfull;
  logic        o_rempty;
  logic [31:0] o_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  async_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
    .i_clk   (i_clk),
    .rst     (rst),
    .i_wdata (i_wdata),
    .i_wr    (i_wr),
    .i_rd    (i_rd),
    .o_wfull (o_wfull),
    .o_rempty(o_rempty),
    .o_rdata (o_rdata)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one rising edge and settle so outputs reflect that edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    i_wdata = '0;
    i_wr    = 1'b0;
    i_rd    = 1'b0;
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("reset_empty", {31'd0, o_rempty}, 32'd1);
    chk("reset_full",  {31'd0, o_wfull},  32'd0);
    chk("reset_rdata", o_rdata, 32'd0);

    // Fill with 0..19; full at the 16th accepted write, 16..19 dropped.
    for (int i = 0; i < 20; i++) begin
      i_wr = 1'b1; i_wdata = i;
      step();
      chk($sformatf("fill_full_%0d", i), {31'd0, o_wfull}, (i >= 15) ? 32'd1 : 32'd0);
      chk($sformatf("fill_empty_%0d", i), {31'd0, o_rempty}, (i < 3) ? 32'd1 : 32'd0);
    end
    i_wr = 1'b0;

    // Drain 23 cycles: 0..15 then hold 15; full falls 3 edges after first read.
    for (int k = 0; k < 23; k++) begin
      i_rd = 1'b1;
      step();
      chk($sformatf("drain_rdata_%0d", k), o_rdata, (k < 16) ? k : 32'd15);
      chk($sformatf("drain_empty_%0d", k), {31'd0, o_rempty}, (k >= 15) ? 32'd1 : 32'd0);
      chk($sformatf("drain_full_%0d", k), {31'd0, o_wfull}, (k < 3) ? 32'd1 : 32'd0);
    end
    i_rd = 1'b0;

    // Full-lag: fill 4,6..34, then 3 simultaneous rd/wr cycles with writes dropped.
    for (int j = 0; j < 16; j++) begin
      i_wr = 1'b1; i_wdata = 4 + 2 * j;
      step();
      chk($sformatf("lag_fill_full_%0d", j), {31'd0, o_wfull}, (j == 15) ? 32'd1 : 32'd0);
    end
    for (int c = 0; c < 3; c++) begin
      i_wr = 1'b1; i_rd = 1'b1; i_wdata = 97 + c;
      step();
      chk($sformatf("flag_rdata_%0d", c), o_rdata, 4 + 2 * c);
      chk($sformatf("flag_full_%0d", c), {31'd0, o_wfull}, 32'd1);
    end
    i_wr = 1'b0; i_rd = 1'b0;
    step();
    chk("flag_full_release", {31'd0, o_wfull}, 32'd0);
    for (int m = 0; m < 14; m++) begin
      i_rd = 1'b1;
      step();
      chk($sformatf("flag_drain_%0d", m), o_rdata, (m < 13) ? 10 + 2 * m : 32'd34);
      chk($sformatf("flag_drain_empty_%0d", m), {31'd0, o_rempty}, (m >= 12) ? 32'd1 : 32'd0);
    end
    i_rd = 1'b0;

    // Move both pointers to 9 (mod 32) before the empty-lag case.
    for (int i = 0; i < 9; i++) begin
      i_wr = 1'b1; i_wdata = 200 + i;
      step();
    end
    i_wr = 1'b0;
    for (int k = 0; k < 3; k++) step();
    for (int i = 0; i < 9; i++) begin
      i_rd = 1'b1;
      step();
      chk($sformatf("prep_rdata_%0d", i), o_rdata, 200 + i);
    end
    i_rd = 1'b0;
    chk("prep_empty", {31'd0, o_rempty}, 32'd1);

    // Empty-lag: reads ignored while empty lags, all writes accepted.
    for (int c = 0; c < 3; c++) begin
      i_wr = 1'b1; i_rd = 1'b1; i_wdata = 88 + c;
      step();
      chk($sformatf("elag_empty_%0d", c), {31'd0, o_rempty}, 32'd1);
      chk($sformatf("elag_rdata_%0d", c), o_rdata, 32'd208);
    end
    i_wr = 1'b0; i_rd = 1'b0;
    step();
    chk("elag_empty_release", {31'd0, o_rempty}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      i_rd = 1'b1;
      step();
      chk($sformatf("elag_read_%0d", c), o_rdata, 88 + c);
      chk($sformatf("elag_read_empty_%0d", c), {31'd0, o_rempty}, (c == 2) ? 32'd1 : 32'd0);
    end
    i_rd = 1'b0;

    // Mid-operation reset with 5 entries stored.
    for (int i = 0; i < 5; i++) begin
      i_wr = 1'b1; i_wdata = 32'h10 + i;
      step();
    end
    i_wr = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("pre_rst_empty", {31'd0, o_rempty}, 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_empty", {31'd0, o_rempty}, 32'd1);
    chk("mid_rst_full",  {31'd0, o_wfull},  32'd0);
    chk("mid_rst_rdata", o_rdata, 32'd0);
    #2;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("post_rst_empty", {31'd0, o_rempty}, 32'd1);
    i_wr = 1'b1; i_wdata = 32'h55;
    step();
    i_wr = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("post_rst_nonempty", {31'd0, o_rempty}, 32'd0);
    i_rd = 1'b1;
    step();
    i_rd = 1'b0;
    chk("post_rst_rdata", o_rdata, 32'h55);
    chk("post_rst_final_empty", {31'd0, o_rempty}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
